// File: rtl/gen_rr_arbiter.sv
// Registered round-robin arbiter: one-hot grant, encoded owner and burst-limited hold.
// Each requester's qualification and winner logic lives in its own g_req scope; pointer, FSM and counter are shared.
module gen_rr_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  parameter int IDW       = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n, base, nxt_ptr, win_id, id_n;
  logic [7:0]     cnt, cnt_n;
  logic [N-1:0]   gnt_n;
  logic [N-1:0]   elig_hi, win, own;
  logic [N:0]     hi_pre, lo_pre;
  logic           any_hi, owner_req, hold;

  assign nxt_ptr = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + IDW'(1);

  // On release the search restarts just past the owner; in IDLE it starts at the pointer.
  always_comb begin
    base = ptr;
    if (state == GRANT) base = nxt_ptr;
  end

  // Prefix-OR chains: "some eligible requester below bit i" for the upper and wrapped search.
  always_comb begin
    hi_pre[0] = 1'b0;
    lo_pre[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      hi_pre[i+1] = hi_pre[i] | elig_hi[i];
      lo_pre[i+1] = lo_pre[i] | req[i];
    end
  end

  assign any_hi = hi_pre[N];

  for (genvar i = 0; i < N; i++) begin : g_req
    assign elig_hi[i] = req[i] && (i >= int'(base));
    assign win[i]     = any_hi ? (elig_hi[i] & ~hi_pre[i]) : (req[i] & ~lo_pre[i]);
    assign own[i]     = req[i] & gnt[i];
  end

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N; i++)
      if (win[i]) win_id = IDW'(i);
  end

  assign owner_req = |own;
  assign hold      = owner_req && (cnt < 8'(MAX_BURST));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    id_n    = gnt_id;
    case (state)
      IDLE: begin
        if (en && |req) begin
          state_n = GRANT;
          gnt_n   = win;
          id_n    = win_id;
          cnt_n   = 8'd1;
        end
      end
      GRANT: begin
        if (hold) begin
          cnt_n = cnt + 8'd1;
        end else begin
          ptr_n = nxt_ptr;
          if (en && |req) begin
            gnt_n = win;
            id_n  = win_id;
            cnt_n = 8'd1;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            id_n    = '0;
            cnt_n   = 8'd0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= 8'd0;
      gnt    <= '0;
      gnt_id <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      gnt    <= gnt_n;
      gnt_id <= id_n;
    end
  end

  assign gnt_valid = |gnt;
  assign busy      = (state == GRANT);

endmodule

// File: tb/tb_gen_rr_arbiter.sv
// Directed bench for gen_rr_arbiter (N=4, MAX_BURST=4): reset, wrap search, burst limit, rotation, en gating, async reset.
module tb_gen_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       en;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       busy;
  int         n_cmp = 0;
  int         n_bad = 0;

  gen_rr_arbiter #(.N(4), .MAX_BURST(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .en(en),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
        n_bad++;
        $display("FAIL reset_hold c%0d: gnt=%b busy=%b vld=%b id=%0d want 0000/0/0/0", c, gnt, busy, gnt_valid, gnt_id);
      end
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1 || gnt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: gnt=%b id=%0d busy=%b vld=%b want 0100/2/1/1", gnt, gnt_id, busy, gnt_valid);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_release: gnt=%b busy=%b vld=%b want 0000/0/0", gnt, busy, gnt_valid);
    end
  endtask

  // Pointer is 3 after owner 2 released; the search must wrap 3->0->1.
  task automatic test_wrap();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      n_bad++;
      $display("FAIL wrap_search: gnt=%b id=%0d want 0010/1", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL wrap_release: gnt=%b want 0000", gnt);
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                             4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (gnt !== exp[c] || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL burst c%0d: gnt=%b busy=%b want %b/1", c, gnt, busy, exp[c]);
      end
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_end: gnt=%b busy=%b want 0000/0", gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] rv  [5] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] eid [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req = rv[c];
      tick();
      n_cmp++;
      if (gnt !== exp[c] || gnt_id !== eid[c]) begin
        n_bad++;
        $display("FAIL rr_order c%0d: gnt=%b id=%0d want %b/%0d", c, gnt, gnt_id, exp[c], eid[c]);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_en_gating();
    en = 1'b0; req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL en_block c%0d: gnt=%b busy=%b want 0000/0", c, gnt, busy);
      end
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      n_bad++;
      $display("FAIL en_start: gnt=%b id=%0d want 1000/3", gnt, gnt_id);
    end
    // Owner keeps requesting to its burst limit while requester 0 waits; en low blocks the handoff.
    en = 1'b0; req = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (c < 3) begin
        if (gnt !== 4'b1000 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL en_finish c%0d: gnt=%b busy=%b want 1000/1", c, gnt, busy);
        end
      end else if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL en_idle c%0d: gnt=%b busy=%b want 0000/0", c, gnt, busy);
      end
    end
    req = 4'b0000; en = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL ar_pre: gnt=%b want 0010", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
      n_bad++;
      $display("FAIL ar_immediate: gnt=%b busy=%b id=%0d want 0000/0/0", gnt, busy, gnt_id);
    end
    req = 4'b0110;
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      n_bad++;
      $display("FAIL ar_after: gnt=%b id=%0d want 0010/1", gnt, gnt_id);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 4'b0000;
    test_reset();
    test_wrap();
    test_burst();
    test_round_robin();
    test_en_gating();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
